// File: rtl/burst_master_pkg.sv
// -----------------------------------------------------------------------------
// burst_master_pkg
//   Shared definitions for the burst_master block:
//     - state_t      : controller states (IDLE, SEND, GAP_WAIT)
//     - STALL_CNT_W  : width of the saturating stall counter output
//     - cnt_width()  : counter width helper, max(1, $clog2(n))
// -----------------------------------------------------------------------------
package burst_master_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  // A counter over n values never collapses to zero bits, so that
  // single-word bursts and zero-gap builds still have a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/burst_word_gen.sv
// -----------------------------------------------------------------------------
// burst_word_gen
//   Maps a word index within a burst to its payload:
//     word = (SEED + idx * STEP) mod 2^DATA_W
//   Purely combinational; the modulo comes for free from DATA_W-bit arithmetic.
//
// Ports
//   idx  [CNT_W-1:0]   in   word index inside the current burst
//   word [DATA_W-1:0]  out  payload for that index
// -----------------------------------------------------------------------------
module burst_word_gen #(
  parameter int                DATA_W = 3,
  parameter int                CNT_W  = 2,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(7),
  parameter logic [DATA_W-1:0] STEP   = DATA_W'(6)
) (
  input  logic [CNT_W-1:0]  idx,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] idx_ext;

  // The index is resized to the payload width before the multiply so the
  // whole expression is evaluated (and wraps) at DATA_W bits.
  assign idx_ext = DATA_W'(idx);
  assign word    = SEED + idx_ext * STEP;

endmodule

// File: rtl/burst_master.sv
// -----------------------------------------------------------------------------
// burst_master
//   Emits fixed-length bursts of generated words on a valid/ready interface.
//   A burst starts one cycle after start is seen in IDLE (or unconditionally
//   when AUTO_RPT=1), presents BURST_LEN words, holds each word stable while
//   the downstream stalls, pulses done on the final transfer, then idles for
//   GAP cycles in GAP_WAIT before returning to IDLE.
//
// Configuration macro
//   BURST_MASTER_STALL_CNT_EN : when defined, stall_cnt counts cycles with
//                               valid_up=1 and ready_up=0, saturating at
//                               all-ones; otherwise stall_cnt is tied to 0.
//
// Ports
//   sys_clk             in   single clock
//   rst                 in   asynchronous active-high reset
//   start               in   burst request, looked at only in IDLE
//   ready_up            in   downstream ready
//   valid_up            out  word valid
//   data_up  [DATA_W]   out  payload, 0 while valid_up=0
//   last_up             out  final word of the burst, 0 while valid_up=0
//   done                out  one-cycle pulse on the final beat transfer
//   busy                out  state is not IDLE
//   stall_cnt [16]      out  saturating stall counter
// -----------------------------------------------------------------------------
module burst_master
  import burst_master_pkg::*;
#(
  parameter int                DATA_W    = 3,
  parameter int                BURST_LEN = 3,
  parameter int                GAP       = 0,
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(7),
  parameter logic [DATA_W-1:0] STEP      = DATA_W'(6),
  parameter int                AUTO_RPT  = 0
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ready_up,
  output logic                   valid_up,
  output logic [DATA_W-1:0]      data_up,
  output logic                   last_up,
  output logic                   done,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int CNT_W = cnt_width(BURST_LEN);
  localparam int GAP_W = cnt_width(GAP);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
  // Only meaningful when GAP > 0; GAP_WAIT is unreachable otherwise.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam bit               AUTO_GO  = (AUTO_RPT != 0);
  localparam bit               HAS_GAP  = (GAP > 0);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  word_idx_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [DATA_W-1:0] word;
  logic              at_last;
  logic              beat;
  logic              final_beat;

  // ---------------------------------------------------------------------------
  // Word generation
  // ---------------------------------------------------------------------------
  burst_word_gen #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .SEED   (SEED),
    .STEP   (STEP)
  ) u_word_gen (
    .idx  (word_idx_q),
    .word (word)
  );

  // ---------------------------------------------------------------------------
  // Handshake decode
  //   Outputs are decoded from registered state only, so they hold stable
  //   through stalls and drop to zero the instant rst asserts.
  // ---------------------------------------------------------------------------
  assign valid_up   = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign at_last    = (word_idx_q == LAST_IDX);
  assign beat       = valid_up & ready_up;
  assign final_beat = beat & at_last;

  assign data_up    = valid_up ? word : '0;
  assign last_up    = valid_up & at_last;
  assign done       = final_beat;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start || AUTO_GO) state_d = SEND;
      end
      SEND: begin
        if (final_beat) state_d = HAS_GAP ? GAP_WAIT : IDLE;
      end
      GAP_WAIT: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, word index and gap counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      // The index moves only on an accepted beat and wraps after the last.
      if (beat) begin
        word_idx_q <= at_last ? '0 : word_idx_q + CNT_W'(1);
      end

      // gap_cnt_q is 0 on entry to GAP_WAIT and back at 0 when it leaves.
      if (state_q == GAP_WAIT) begin
        gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? '0 : gap_cnt_q + GAP_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall counter
  // ---------------------------------------------------------------------------
`ifdef BURST_MASTER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (valid_up && !ready_up && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/burst_master.md
BURST_MASTER -- requirements
Module: burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 3, meaning payload width in bits (legal: >=1).
REQ-002 SHALL have parameter BURST_LEN, default 3, meaning words per burst (legal: >=1).
REQ-003 SHALL have parameter GAP, default 0, meaning idle cycles forced after each burst (legal: >=0).
REQ-004 SHALL have parameters SEED, default 7, and STEP, default 6, meaning first word and per-word increment (DATA_W bits each).
REQ-005 SHALL have parameter AUTO_RPT, default 0, meaning 1 = bursts restart without start.
REQ-006 SHALL have port sys_clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit, burst request, sampled only in IDLE.
REQ-009 SHALL have port ready_up, input, 1 bit, downstream ready.
REQ-010 SHALL have port valid_up, output, 1 bit, word valid.
REQ-011 SHALL have port data_up, output, DATA_W bits, payload.
REQ-012 SHALL have port last_up, output, 1 bit, final word of burst.
REQ-013 SHALL have port done, output, 1 bit, one-cycle burst-complete pulse.
REQ-014 SHALL have port busy, output, 1 bit, high when state is not IDLE.
REQ-015 SHALL have port stall_cnt, output, 16 bits, saturating stall counter.

Function
REQ-016 SHALL implement states IDLE, SEND and GAP_WAIT.
REQ-017 IDLE -> SEND on a cycle with start=1 or AUTO_RPT=1; valid_up SHALL rise the following cycle (1-cycle latency).
REQ-018 Word k (k = 0..BURST_LEN-1) SHALL equal (SEED + k*STEP) mod 2^DATA_W.
REQ-019 A beat transfers only on a cycle with valid_up=1 and ready_up=1; word index SHALL advance the next cycle.
REQ-020 While valid_up=1 and ready_up=0, valid_up, data_up and last_up SHALL hold stable.
REQ-021 valid_up SHALL NOT deassert inside a burst before the final beat transfers.
REQ-022 last_up SHALL be 1 exactly while word BURST_LEN-1 is presented; with BURST_LEN=1 it SHALL accompany word 0.
REQ-023 On the final beat transfer, done SHALL pulse for that same cycle, and the next state SHALL be GAP_WAIT if GAP>0, else IDLE.
REQ-024 GAP_WAIT SHALL last exactly GAP cycles, then enter IDLE; start SHALL be ignored outside IDLE.
REQ-025 data_up and last_up SHALL be 0 whenever valid_up=0.
REQ-026 The word counter SHALL be max(1,$clog2(BURST_LEN)) bits wide and SHALL wrap to 0 after the final beat.
REQ-027 start held high continuously SHALL yield back-to-back bursts separated by exactly GAP+1 cycles with valid_up=0.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counters 0, valid_up=0, data_up=0, last_up=0, done=0, busy=0, stall_cnt=0, including mid-burst.
REQ-029 After rst deasserts, the first burst SHALL start only per REQ-017.

Configuration
REQ-030 With macro BURST_MASTER_STALL_CNT_EN defined, stall_cnt SHALL increment on each cycle with valid_up=1 and ready_up=0, saturating at 16'hFFFF.
REQ-031 Without BURST_MASTER_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-032 Package burst_master_pkg SHALL hold the state enum (IDLE, SEND, GAP_WAIT) and constant STALL_CNT_W = 16.
REQ-033 Word generation SHALL be a sub-module, burst_word_gen, that maps index to word per REQ-018.

Verification
REQ-034 Defaults, ready_up=1, one-cycle start pulse -> data_up 7,5,3 on three consecutive cycles; last_up and done high with 3; then valid_up=0.
REQ-035 Defaults, ready_up low for 4 cycles during word 5 -> data_up holds 5 and valid_up stays 1; stall_cnt=4 with the macro defined, 0 without.
REQ-036 GAP=2, start held high -> bursts separated by exactly 3 cycles with valid_up=0.
REQ-037 BURST_LEN=1, DATA_W=8, SEED=8'hA5 -> a single beat of A5 with last_up=1 and done=1.
REQ-038 rst pulsed while word 5 is pending -> all outputs 0 at once, IDLE entered; the next start yields 7 first.
REQ-039 AUTO_RPT=1, start=0, ready_up=1 -> a continuous 7,5,3 stream with one idle cycle between bursts.
